// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types, digit counts and glyph table for the seven-segment scan driver.
package seg7_pkg;
  typedef logic [7:0] seg_t;
  localparam int NUM_DIG  = 8;
  localparam int BANK_DIG = 4;
  localparam seg_t SEG_OFF = 8'h00;
  localparam seg_t GLYPH [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };
endpackage

// File: rtl/seg7_glyph_dec.sv
// seg7_glyph_dec: combinational hex nibble plus decimal point to {dp,g..a} pattern.
module seg7_glyph_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dot,
  output seg_t       seg
);
  assign seg = {dot, GLYPH[nib][6:0]};
endmodule

// File: rtl/seg7_scan_drv.sv
// seg7_scan_drv: double-buffered 8-digit multiplexed seven-segment scanner.
// Optional leading-zero blanking per 4-digit bank when SEG7_LZB_EN is defined.
module seg7_scan_drv
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 16,
  parameter int DIV_W    = $clog2(SCAN_DIV)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] digit_i,
  input  logic [7:0]  dot_i,
  input  logic [7:0]  blank_i,
  input  logic        upd_i,
  output logic [7:0]  seg7_sel,
  output seg_t        seg7,
  output seg_t        seg7_l,
  output logic        frame_o
);
  logic [DIV_W-1:0] div;
  logic [$clog2(NUM_DIG)-1:0] slot;
  logic pending, tc, wrap, dark;
  logic [31:0] sh_dig, act_dig;
  logic [7:0] sh_dot, act_dot, sh_blank, act_blank, lzb;
  logic [3:0] nib;
  seg_t pat, shown;
  assign tc   = div == DIV_W'(SCAN_DIV - 1);
  assign wrap = tc && slot == 3'(NUM_DIG - 1);
`ifdef SEG7_LZB_EN
  logic [7:0] z;
  always_comb begin
    for (int i = 0; i < NUM_DIG; i++) z[i] = act_dig[4*i +: 4] == 4'd0 && !act_dot[i];
    lzb = {z[7], &z[7:6], &z[7:5], 1'b0, z[3], &z[3:2], &z[3:1], 1'b0};
  end
`else
  assign lzb = '0;
`endif
  assign nib = act_dig[{slot, 2'b00} +: 4];
  seg7_glyph_dec u_dec (.nib(nib), .dot(act_dot[slot]), .seg(pat));
  assign dark  = act_blank[slot] | lzb[slot];
  assign shown = dark ? SEG_OFF : pat;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div       <= '0;
      slot      <= '0;
      pending   <= 1'b0;
      sh_dig    <= '0;
      sh_dot    <= '0;
      sh_blank  <= 8'hFF;
      act_dig   <= '0;
      act_dot   <= '0;
      act_blank <= 8'hFF;
      seg7_sel  <= '0;
      seg7      <= SEG_OFF;
      seg7_l    <= SEG_OFF;
      frame_o   <= 1'b0;
    end else begin
      div      <= tc ? '0 : div + DIV_W'(1);
      slot     <= tc ? slot + 3'd1 : slot;
      seg7_sel <= 8'(1) << slot;
      seg7     <= slot >= 3'(BANK_DIG) ? SEG_OFF : shown;
      seg7_l   <= slot >= 3'(BANK_DIG) ? shown : SEG_OFF;
      frame_o  <= wrap;
      if (upd_i) begin
        sh_dig   <= digit_i;
        sh_dot   <= dot_i;
        sh_blank <= blank_i;
      end
      // A strobe on the wrap cycle bypasses the shadow so it is not lost for a frame
      if (wrap) begin
        pending <= 1'b0;
        if (upd_i) begin
          act_dig   <= digit_i;
          act_dot   <= dot_i;
          act_blank <= blank_i;
        end else if (pending) begin
          act_dig   <= sh_dig;
          act_dot   <= sh_dot;
          act_blank <= sh_blank;
        end
      end else if (upd_i) pending <= 1'b1;
    end
endmodule

// File: tb/tb_seg7_scan_drv.sv
// tb_seg7_scan_drv: randomized and directed checks of seg7_scan_drv against a cycle-count reference model.
module tb_seg7_scan_drv;
  localparam int SD = 4;
  localparam int FR = SD * 8;
  logic clk = 0, rst_n = 0, upd = 0;
  logic [31:0] digit = 0;
  logic [7:0] dot = 0, blank = 0;
  logic [7:0] seg7_sel, seg7, seg7_l;
  logic frame_o;
  int n_vec = 0, n_err = 0;

  seg7_scan_drv #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .digit_i(digit), .dot_i(dot), .blank_i(blank), .upd_i(upd),
    .seg7_sel(seg7_sel), .seg7(seg7), .seg7_l(seg7_l), .frame_o(frame_o)
  );
  always #5 clk = ~clk;

  logic [7:0] gl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                          8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  int m_n;
  logic [31:0] m_dig, s_dig;
  logic [7:0] m_dot, m_blk, s_dot, s_blk;
  bit m_pend;
  logic [24:0] exp_v;

  function automatic int nib_of(int k);
    return int'((m_dig >> (4 * k)) & 32'hF);
  endfunction

  function automatic logic [7:0] pat_of(int k);
    bit dark = m_blk[k];
`ifdef SEG7_LZB_EN
    int b = (k / 4) * 4;
    if (k != b) begin
      bit all0 = 1;
      for (int j = k; j < b + 4; j++) if (nib_of(j) != 0 || m_dot[j]) all0 = 0;
      if (all0) dark = 1;
    end
`endif
    return dark ? 8'h00 : {m_dot[k], gl[nib_of(k)][6:0]};
  endfunction

  // Reference: slot and frame position follow directly from the edge count since reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0; m_dig = 0; m_dot = 0; m_blk = 8'hFF;
      s_dig = 0; s_dot = 0; s_blk = 8'hFF; m_pend = 0; exp_v = 0;
    end else begin
      int s;
      bit w;
      logic [7:0] p;
      s = (m_n / SD) % 8;
      w = (m_n % FR) == FR - 1;
      p = pat_of(s);
      exp_v = {8'(1 << s), s < 4 ? p : 8'h00, s < 4 ? 8'h00 : p, w};
      if (w) begin
        if (upd) begin m_dig = digit; m_dot = dot; m_blk = blank; end
        else if (m_pend) begin m_dig = s_dig; m_dot = s_dot; m_blk = s_blk; end
        m_pend = 0;
      end else if (upd) m_pend = 1;
      if (upd) begin s_dig = digit; s_dot = dot; s_blk = blank; end
      m_n++;
    end
  end

  task automatic wait_phase(int ph);
    for (int i = 0; i < 2 * FR && (m_n % FR) != ph; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    int frames = 0;
    rst_n = 0; upd = 0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({seg7_sel, seg7, seg7_l, frame_o} !== 25'd0) begin
      n_err++; $display("FAIL reset_vals: got %h expected 0", {seg7_sel, seg7, seg7_l, frame_o});
    end
    rst_n = 1;
    @(negedge clk);
    n_vec++;
    if (seg7_sel !== 8'h01) begin n_err++; $display("FAIL first_slot: got %h expected 01", seg7_sel); end
    for (int i = 0; i < 64; i++) begin
      n_vec++;
      if ({seg7_sel, seg7, seg7_l, frame_o} !== exp_v || (seg7 | seg7_l) !== 8'h00) begin
        n_err++; $display("FAIL idle_scan: got %h expected %h", {seg7_sel, seg7, seg7_l, frame_o}, exp_v);
      end
      frames += int'(frame_o);
      @(negedge clk);
    end
    n_vec++;
    if (frames != 2) begin n_err++; $display("FAIL frame_count: got %0d expected 2", frames); end
  endtask

  task automatic test_update();
    bit seen = 0;
    wait_phase(10);
    digit = 32'h76543210; dot = 0; blank = 0; upd = 1;
    @(negedge clk);
    upd = 0;
    for (int i = 0; i < 2 * FR && !seen; i++) begin
      n_vec++;
      if ({seg7_sel, seg7, seg7_l, frame_o} !== exp_v || (seg7 | seg7_l) !== 8'h00) begin
        n_err++; $display("FAIL old_frame: got %h expected %h", {seg7_sel, seg7, seg7_l, frame_o}, exp_v);
      end
      seen = frame_o;
      if (!seen) @(negedge clk);
    end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL update_timeout: got no frame expected frame_o"); end
    for (int i = 0; i < FR; i++) begin
      @(negedge clk);
      n_vec++;
      if ({seg7_sel, seg7, seg7_l, frame_o} !== exp_v) begin
        n_err++; $display("FAIL update_scan: got %h expected %h", {seg7_sel, seg7, seg7_l, frame_o}, exp_v);
      end
      if ((i == 0 && seg7 !== 8'h3F) || (i == 4 && seg7 !== 8'h06) ||
          (i == 16 && seg7_l !== 8'h66) || (i == 28 && seg7_l !== 8'h07)) begin
        n_err++; $display("FAIL update_glyph: slot %0d got %h/%h", i / 4, seg7, seg7_l);
      end
    end
  endtask

  task automatic test_wrap_bypass();
    wait_phase(FR - 1);
    digit = 32'hFFFFFFFF; dot = 8'h81; blank = 0; upd = 1;
    @(negedge clk);
    upd = 0;
    n_vec++;
    if (frame_o !== 1'b1) begin n_err++; $display("FAIL wrap_frame: got %b expected 1", frame_o); end
    for (int i = 0; i < FR; i++) begin
      @(negedge clk);
      n_vec++;
      if ({seg7_sel, seg7, seg7_l, frame_o} !== exp_v) begin
        n_err++; $display("FAIL bypass_scan: got %h expected %h", {seg7_sel, seg7, seg7_l, frame_o}, exp_v);
      end
      if ((i == 0 && seg7 !== 8'hF1) || (i == 4 && seg7 !== 8'h71) ||
          (i == 16 && seg7_l !== 8'h71) || (i == 28 && seg7_l !== 8'hF1)) begin
        n_err++; $display("FAIL bypass_glyph: slot %0d got %h/%h", i / 4, seg7, seg7_l);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lit = 0;
    wait_phase(5);
    blank = 8'hFE; dot = 0; digit = 32'h1; upd = 1;
    @(negedge clk);
    digit = 32'h2;
    @(negedge clk);
    upd = 0;
    for (int i = 0; i < 3 * FR; i++) begin
      n_vec++;
      if ({seg7_sel, seg7, seg7_l, frame_o} !== exp_v || seg7 === 8'h06) begin
        n_err++; $display("FAIL b2b_scan: got %h expected %h", {seg7_sel, seg7, seg7_l, frame_o}, exp_v);
      end
      if (seg7_sel === 8'h01 && seg7 === 8'h5B) lit++;
      @(negedge clk);
    end
    n_vec++;
    if (lit < SD) begin n_err++; $display("FAIL b2b_last_wins: got %0d cycles of 5B expected >= %0d", lit, SD); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2 * FR && seg7_sel !== 8'h20; i++) @(negedge clk);
    n_vec++;
    if (seg7_sel !== 8'h20) begin n_err++; $display("FAIL mid_slot5: got %h expected 20", seg7_sel); end
    #1 rst_n = 0;
    #1;
    n_vec++;
    if ({seg7_sel, seg7, seg7_l, frame_o} !== 25'd0) begin
      n_err++; $display("FAIL async_reset: got %h expected 0", {seg7_sel, seg7, seg7_l, frame_o});
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    n_vec++;
    if (seg7_sel !== 8'h01) begin n_err++; $display("FAIL restart_slot0: got %h expected 01", seg7_sel); end
    for (int i = 0; i < 40; i++) begin
      n_vec++;
      if ({seg7_sel, seg7, seg7_l, frame_o} !== exp_v || (seg7 | seg7_l) !== 8'h00) begin
        n_err++; $display("FAIL dark_after_reset: got %h expected %h", {seg7_sel, seg7, seg7_l, frame_o}, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lzb();
    bit seen = 0;
    logic [7:0] ex [8];
`ifdef SEG7_LZB_EN
    ex = '{8'h3F, 8'h5B, 8'h00, 8'h00, 8'h3F, 8'h06, 8'h00, 8'h00};
`else
    ex = '{8'h3F, 8'h5B, 8'h3F, 8'h3F, 8'h3F, 8'h06, 8'h3F, 8'h3F};
`endif
    wait_phase(10);
    digit = 32'h00100020; dot = 0; blank = 0; upd = 1;
    @(negedge clk);
    upd = 0;
    for (int i = 0; i < 2 * FR && !seen; i++) begin
      seen = frame_o;
      if (!seen) @(negedge clk);
    end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL lzb_timeout: got no frame expected frame_o"); end
    for (int i = 0; i < FR; i++) begin
      logic [7:0] act;
      @(negedge clk);
      act = i < 16 ? seg7 : seg7_l;
      n_vec++;
      if ({seg7_sel, seg7, seg7_l, frame_o} !== exp_v || act !== ex[i / 4]) begin
        n_err++; $display("FAIL lzb_digit%0d: got %h expected %h", i / 4, act, ex[i / 4]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      n_vec++;
      if ({seg7_sel, seg7, seg7_l, frame_o} !== exp_v) begin
        n_err++; $display("FAIL random_%0d: got %h expected %h", i, {seg7_sel, seg7, seg7_l, frame_o}, exp_v);
      end
      upd = $urandom_range(0, 7) == 0;
      digit = $urandom;
      dot = 8'($urandom);
      blank = 8'($urandom & $urandom);
      @(negedge clk);
    end
    upd = 0;
  endtask

  initial begin
    test_reset();
    test_update();
    test_wrap_bypass();
    test_back_to_back();
    test_reset_mid();
    test_lzb();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
